// File: rtl/gnrc_fifo_wm.sv
// rtl/gnrc_fifo_wm.sv - FWFT valid/ready FIFO with exact count, runtime watermarks and high-water mark
module gnrc_fifo_wm #(
    parameter int DW = 32,
    parameter int DP = 16,
    parameter int CW = $clog2(DP + 1)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          flush_i,
    input  logic [DW-1:0] in_data_i,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    output logic [DW-1:0] out_data_o,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    input  logic [CW-1:0] afull_thr_i,
    input  logic [CW-1:0] aempty_thr_i,
    output logic [CW-1:0] cnt_o,
    output logic          full_o,
    output logic          empty_o,
    output logic          afull_o,
    output logic          aempty_o,
    output logic [CW-1:0] hwm_o,
    input  logic          hwm_clr_i
);

    localparam int AW = (DP > 1) ? $clog2(DP) : 1;
    localparam logic [AW-1:0] LAST_PTR = AW'(DP - 1);
    localparam logic [CW-1:0] DP_CNT   = CW'(DP);
    localparam logic [CW-1:0] ONE_CNT  = CW'(1);

    logic [DW-1:0] r_mem [DP];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] r_hwm;
    logic [DW-1:0] r_out_data;
    logic          r_out_valid;
    logic          r_in_ready;
    logic          r_full;
    logic          r_empty;
    logic          r_afull;
    logic          r_aempty;

    logic          w_push;
    logic          w_pop;
    logic [AW-1:0] w_wr_ptr_inc;
    logic [AW-1:0] w_rd_ptr_inc;
    logic [AW-1:0] w_rd_ptr_sel;
    logic [CW-1:0] w_cnt_arith;
    logic [CW-1:0] w_cnt_nxt;
    logic [CW-1:0] w_hwm_nxt;

    // Handshakes and next-state arithmetic; flush collapses the count to zero
    always_comb begin
        w_push       = in_valid_i & r_in_ready;
        w_pop        = r_out_valid & out_ready_i;
        w_wr_ptr_inc = (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
        w_rd_ptr_inc = (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + 1'b1;
        w_rd_ptr_sel = w_pop ? w_rd_ptr_inc : r_rd_ptr;
        w_cnt_arith  = r_cnt + CW'(w_push) - CW'(w_pop);
        w_cnt_nxt    = flush_i ? '0 : w_cnt_arith;
        if (hwm_clr_i)
            w_hwm_nxt = w_cnt_nxt;
        else
            w_hwm_nxt = (w_cnt_nxt > r_hwm) ? w_cnt_nxt : r_hwm;
    end

    // Storage array carries no reset so it can map onto distributed or block RAM
    always_ff @(posedge clk_i) begin
        if (w_push && !flush_i)
            r_mem[r_wr_ptr] <= in_data_i;
    end

    // Pointers, count, registered head copy, flags and high-water mark
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_cnt       <= '0;
            r_hwm       <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_full      <= 1'b0;
            r_empty     <= 1'b1;
            r_afull     <= 1'b0;
            r_aempty    <= 1'b1;
        end else begin
            if (flush_i) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_push)
                    r_wr_ptr <= w_wr_ptr_inc;
                r_rd_ptr <= w_rd_ptr_sel;
                // A lone entry after this edge is the one being written now, so take it from the input
                if (w_cnt_arith != '0)
                    r_out_data <= (w_push && (w_cnt_arith == ONE_CNT)) ? in_data_i : r_mem[w_rd_ptr_sel];
            end
            r_cnt       <= w_cnt_nxt;
            r_hwm       <= w_hwm_nxt;
            r_out_valid <= (w_cnt_nxt != '0);
            r_in_ready  <= (w_cnt_nxt != DP_CNT);
            r_full      <= (w_cnt_nxt == DP_CNT);
            r_empty     <= (w_cnt_nxt == '0);
            r_afull     <= (w_cnt_nxt >= afull_thr_i);
            r_aempty    <= (w_cnt_nxt <= aempty_thr_i);
        end
    end

    assign in_ready_o  = r_in_ready;
    assign out_data_o  = r_out_data;
    assign out_valid_o = r_out_valid;
    assign cnt_o       = r_cnt;
    assign full_o      = r_full;
    assign empty_o     = r_empty;
    assign afull_o     = r_afull;
    assign aempty_o    = r_aempty;
    assign hwm_o       = r_hwm;

endmodule

// File: tb/tb_gnrc_fifo_wm.sv
// tb/tb_gnrc_fifo_wm.sv - directed self-checking bench for gnrc_fifo_wm
module tb_gnrc_fifo_wm;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          total = 0;
    int          bad = 0;

    // DP=16 instance
    logic        flush_a = 0, in_valid_a = 0, out_ready_a = 0, hwm_clr_a = 0;
    logic [31:0] in_data_a = '0, out_data_a;
    logic        in_ready_a, out_valid_a, full_a, empty_a, afull_a, aempty_a;
    logic [4:0]  afull_thr_a = 5'd12, aempty_thr_a = 5'd2, cnt_a, hwm_a;

    // DP=5 instance
    logic        flush_b = 0, in_valid_b = 0, out_ready_b = 0, hwm_clr_b = 0;
    logic [7:0]  in_data_b = '0, out_data_b;
    logic        in_ready_b, out_valid_b, full_b, empty_b, afull_b, aempty_b;
    logic [2:0]  afull_thr_b = 3'd4, aempty_thr_b = 3'd1, cnt_b, hwm_b;

    gnrc_fifo_wm #(.DW(32), .DP(16)) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush_a),
        .in_data_i(in_data_a), .in_valid_i(in_valid_a), .in_ready_o(in_ready_a),
        .out_data_o(out_data_a), .out_valid_o(out_valid_a), .out_ready_i(out_ready_a),
        .afull_thr_i(afull_thr_a), .aempty_thr_i(aempty_thr_a), .cnt_o(cnt_a),
        .full_o(full_a), .empty_o(empty_a), .afull_o(afull_a), .aempty_o(aempty_a),
        .hwm_o(hwm_a), .hwm_clr_i(hwm_clr_a)
    );

    gnrc_fifo_wm #(.DW(8), .DP(5)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush_b),
        .in_data_i(in_data_b), .in_valid_i(in_valid_b), .in_ready_o(in_ready_b),
        .out_data_o(out_data_b), .out_valid_o(out_valid_b), .out_ready_i(out_ready_b),
        .afull_thr_i(afull_thr_b), .aempty_thr_i(aempty_thr_b), .cnt_o(cnt_b),
        .full_o(full_b), .empty_o(empty_b), .afull_o(afull_b), .aempty_o(aempty_b),
        .hwm_o(hwm_b), .hwm_clr_i(hwm_clr_b)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        logic [42:0] got;
        logic [42:0] exp;
        got = {cnt_a, out_valid_a, out_data_a, in_ready_a, full_a, empty_a, afull_a, aempty_a};
        exp = {5'd0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s outputs: got %h expected %h", tag, got, exp);
        end
        total++;
        if (hwm_a !== 5'd0) begin
            bad++;
            $display("FAIL %s hwm: got %0d expected 0", tag, hwm_a);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        check_reset_values("reset");
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_reset_values("post_release");
    endtask

    task automatic test_fill_drain();
        out_ready_a = 0;
        for (int k = 1; k <= 16; k++) begin
            in_valid_a = 1;
            in_data_a  = 32'(k - 1);
            tick();
            total++;
            if (cnt_a !== 5'(k)) begin
                bad++;
                $display("FAIL fill_cnt k=%0d: got %0d expected %0d", k, cnt_a, k);
            end
            total++;
            if (afull_a !== (k >= 12)) begin
                bad++;
                $display("FAIL fill_afull k=%0d: got %b expected %b", k, afull_a, (k >= 12));
            end
            total++;
            if (aempty_a !== (k <= 2)) begin
                bad++;
                $display("FAIL fill_aempty k=%0d: got %b expected %b", k, aempty_a, (k <= 2));
            end
        end
        total++;
        if ({in_ready_a, full_a} !== 2'b01) begin
            bad++;
            $display("FAIL full_flags: got ready/full %b%b expected 01", in_ready_a, full_a);
        end
        in_data_a = 32'd99;
        tick();
        tick();
        total++;
        if (cnt_a !== 5'd16) begin
            bad++;
            $display("FAIL overfill_cnt: got %0d expected 16", cnt_a);
        end
        in_valid_a  = 0;
        out_ready_a = 1;
        for (int i = 0; i < 16; i++) begin
            total++;
            if (out_valid_a !== 1'b1 || out_data_a !== 32'(i)) begin
                bad++;
                $display("FAIL drain i=%0d: got v=%b d=%0d expected v=1 d=%0d", i, out_valid_a, out_data_a, i);
            end
            tick();
        end
        out_ready_a = 0;
        total++;
        if ({empty_a, cnt_a} !== {1'b1, 5'd0}) begin
            bad++;
            $display("FAIL drained: got empty=%b cnt=%0d expected 1/0", empty_a, cnt_a);
        end
        total++;
        if (hwm_a !== 5'd16) begin
            bad++;
            $display("FAIL hwm_full: got %0d expected 16", hwm_a);
        end
        hwm_clr_a = 1;
        tick();
        hwm_clr_a = 0;
        total++;
        if (hwm_a !== 5'd0) begin
            bad++;
            $display("FAIL hwm_clr_empty: got %0d expected 0", hwm_a);
        end
    endtask

    task automatic test_latency_stall();
        in_valid_a = 1;
        in_data_a  = 32'hA5;
        tick();
        in_valid_a = 0;
        total++;
        if ({out_valid_a, out_data_a, cnt_a} !== {1'b1, 32'hA5, 5'd1}) begin
            bad++;
            $display("FAIL latency: got v=%b d=%h cnt=%0d expected 1/a5/1", out_valid_a, out_data_a, cnt_a);
        end
        for (int s = 0; s < 3; s++) begin
            tick();
            total++;
            if ({out_valid_a, out_data_a} !== {1'b1, 32'hA5}) begin
                bad++;
                $display("FAIL stall s=%0d: got v=%b d=%h expected 1/a5", s, out_valid_a, out_data_a);
            end
        end
        out_ready_a = 1;
        tick();
        out_ready_a = 0;
        total++;
        if ({empty_a, cnt_a, out_valid_a} !== {1'b1, 5'd0, 1'b0}) begin
            bad++;
            $display("FAIL pop_one: got empty=%b cnt=%0d v=%b expected 1/0/0", empty_a, cnt_a, out_valid_a);
        end
    endtask

    task automatic test_back_to_back();
        out_ready_a = 0;
        for (int i = 0; i < 5; i++) begin
            in_valid_a = 1;
            in_data_a  = 32'(100 + i);
            tick();
        end
        for (int i = 0; i < 50; i++) begin
            in_valid_a  = 1;
            in_data_a   = 32'(105 + i);
            out_ready_a = 1;
            total++;
            if (out_valid_a !== 1'b1 || out_data_a !== 32'(100 + i)) begin
                bad++;
                $display("FAIL b2b_data i=%0d: got v=%b d=%0d expected v=1 d=%0d", i, out_valid_a, out_data_a, 100 + i);
            end
            tick();
            total++;
            if (cnt_a !== 5'd5) begin
                bad++;
                $display("FAIL b2b_cnt i=%0d: got %0d expected 5", i, cnt_a);
            end
        end
        in_valid_a = 0;
        for (int i = 0; i < 5; i++) begin
            total++;
            if (out_valid_a !== 1'b1 || out_data_a !== 32'(150 + i)) begin
                bad++;
                $display("FAIL b2b_tail i=%0d: got v=%b d=%0d expected v=1 d=%0d", i, out_valid_a, out_data_a, 150 + i);
            end
            tick();
        end
        out_ready_a = 0;
    endtask

    task automatic test_full_pop_push();
        for (int i = 0; i < 16; i++) begin
            in_valid_a = 1;
            in_data_a  = 32'(200 + i);
            tick();
        end
        in_data_a   = 32'd300;
        out_ready_a = 1;
        tick();
        total++;
        if ({cnt_a, in_ready_a} !== {5'd15, 1'b1}) begin
            bad++;
            $display("FAIL full_pop: got cnt=%0d rdy=%b expected 15/1", cnt_a, in_ready_a);
        end
        out_ready_a = 0;
        tick();
        in_valid_a = 0;
        total++;
        if ({cnt_a, full_a} !== {5'd16, 1'b1}) begin
            bad++;
            $display("FAIL full_repush: got cnt=%0d full=%b expected 16/1", cnt_a, full_a);
        end
        out_ready_a = 1;
        for (int i = 0; i < 16; i++) begin
            total++;
            if (out_data_a !== ((i < 15) ? 32'(201 + i) : 32'd300)) begin
                bad++;
                $display("FAIL full_order i=%0d: got %0d expected %0d", i, out_data_a, (i < 15) ? 201 + i : 300);
            end
            tick();
        end
        out_ready_a = 0;
    endtask

    task automatic test_wrap();
        int wr_idx;
        int rd_idx;
        int cyc;
        wr_idx = 0;
        rd_idx = 0;
        cyc = 0;
        while (rd_idx < 20 && cyc < 2000) begin
            in_valid_b  = (wr_idx < 20) && ($urandom_range(0, 1) == 1);
            in_data_b   = 8'(wr_idx);
            out_ready_b = ($urandom_range(0, 2) != 0);
            if (out_valid_b && out_ready_b) begin
                total++;
                if (out_data_b !== 8'(rd_idx)) begin
                    bad++;
                    $display("FAIL wrap_order: got %0d expected %0d", out_data_b, rd_idx);
                end
                rd_idx++;
            end
            if (in_valid_b && in_ready_b)
                wr_idx++;
            tick();
            cyc++;
        end
        in_valid_b  = 0;
        out_ready_b = 0;
        total++;
        if (rd_idx != 20) begin
            bad++;
            $display("FAIL wrap_timeout: got %0d items expected 20", rd_idx);
        end
    endtask

    task automatic test_hwm_flush_reset();
        hwm_clr_a = 1;
        tick();
        hwm_clr_a = 0;
        for (int i = 0; i < 9; i++) begin
            in_valid_a = 1;
            in_data_a  = 32'(400 + i);
            tick();
        end
        total++;
        if ({cnt_a, hwm_a} !== {5'd9, 5'd9}) begin
            bad++;
            $display("FAIL hwm9: got cnt=%0d hwm=%0d expected 9/9", cnt_a, hwm_a);
        end
        flush_a = 1;
        tick();
        flush_a    = 0;
        in_valid_a = 0;
        total++;
        if ({cnt_a, empty_a, out_valid_a, in_ready_a, hwm_a} !== {5'd0, 1'b1, 1'b0, 1'b1, 5'd9}) begin
            bad++;
            $display("FAIL flush: got cnt=%0d e=%b v=%b r=%b hwm=%0d expected 0/1/0/1/9",
                     cnt_a, empty_a, out_valid_a, in_ready_a, hwm_a);
        end
        hwm_clr_a = 1;
        tick();
        hwm_clr_a = 0;
        total++;
        if (hwm_a !== 5'd0) begin
            bad++;
            $display("FAIL hwm_clr: got %0d expected 0", hwm_a);
        end
        for (int i = 0; i < 3; i++) begin
            in_valid_a = 1;
            in_data_a  = 32'(500 + i);
            tick();
        end
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("mid_reset");
        in_valid_a = 0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_reset_values("mid_reset_release");
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_latency_stall();
        test_back_to_back();
        test_full_pop_push();
        test_wrap();
        test_hwm_flush_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
